// File: rtl/block_pack.sv
// -----------------------------------------------------------------------------
// block_pack
// Collects variable-size groups of elements (0..ELMS per transfer) into full
// blocks of ELMS elements. A flush request emits whatever partial block
// remains once all full blocks have drained. Arrival order is preserved: the
// oldest element always leaves on element 0.
//
// Parameters
//   ELMS  element slots per block
//   DATA  bits per element
//   CNT   element-count width
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   input group offered
//   in_ready   input group accepted when in_valid & in_ready
//   in_data    input elements, valid ones packed from element 0
//   in_cnt     number of valid elements in in_data (values > ELMS clamp)
//   flush      single-cycle request to emit a partial block
//   out_valid  output block offered
//   out_ready  output block consumed when out_valid & out_ready
//   out_data   packed block, oldest element at element 0
//   out_cnt    valid elements in out_data (0 when out_valid is low)
//
// Build option
//   BLOCK_PACK_ZERO_FILL_EN  when defined, out_data elements at index
//                            >= out_cnt read as zero; otherwise they carry
//                            stale slot contents.
// -----------------------------------------------------------------------------
module block_pack #(
    parameter int ELMS = 8,
    parameter int DATA = 8,
    parameter int CNT  = $clog2(ELMS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELMS-1:0][DATA-1:0] in_data,
    input  logic [CNT-1:0]            in_cnt,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ELMS-1:0][DATA-1:0] out_data,
    output logic [CNT-1:0]            out_cnt
);

    localparam int OCC_W  = $clog2(2 * ELMS + 1);
    localparam int FLAT_W = 2 * ELMS * DATA;

    // Two blocks of storage: one block can be waiting on the consumer while
    // a further block is accepted behind it.
    logic [2*ELMS-1:0][DATA-1:0] slots_p0;
    logic [2*ELMS-1:0][DATA-1:0] slots_nxt;
    logic [OCC_W-1:0]            occ_p0;
    logic [OCC_W-1:0]            occ_nxt;
    logic                        flush_pend_p0;
    logic                        flush_pend_nxt;

    logic                        full;
    logic [OCC_W-1:0]            out_cnt_w;
    logic [OCC_W-1:0]            popped;
    logic [OCC_W-1:0]            pushed;
    logic [OCC_W-1:0]            kept;
    logic [FLAT_W-1:0]           shifted;
    logic [FLAT_W-1:0]           ins_data;
    logic [FLAT_W-1:0]           ins_mask;
    logic [ELMS*DATA-1:0]        in_masked;
    logic [ELMS*DATA-1:0]        in_keep;

    // Saturate the offered count to one block.
    function automatic logic [OCC_W-1:0] clamp_cnt(input logic [CNT-1:0] c);
        logic [OCC_W-1:0] w;
        w = OCC_W'(c);
        return (w > OCC_W'(ELMS)) ? OCC_W'(ELMS) : w;
    endfunction

    // Handshake status, derived only from registered state.
    always_comb begin
        full      = (occ_p0 >= OCC_W'(ELMS));
        in_ready  = (occ_p0 <= OCC_W'(ELMS)) & ~flush_pend_p0;
        out_valid = full | (flush_pend_p0 & (occ_p0 != '0));
        if (!out_valid) begin
            out_cnt_w = '0;
        end else if (full) begin
            out_cnt_w = OCC_W'(ELMS);
        end else begin
            out_cnt_w = occ_p0;
        end
        popped = (out_valid & out_ready) ? out_cnt_w : '0;
        pushed = (in_valid & in_ready) ? clamp_cnt(in_cnt) : '0;
        kept   = occ_p0 - popped;
    end

    // out_cnt never exceeds ELMS, so the narrower port holds it exactly.
    assign out_cnt = out_cnt_w[CNT-1:0];

    // Next buffer contents: survivors slide down by the popped count, then
    // the accepted elements land directly behind them.
    always_comb begin
        in_keep = '0;
        for (int i = 0; i < ELMS; i++) begin
            if (OCC_W'(i) < pushed) begin
                in_keep[i*DATA +: DATA] = '1;
            end
        end
        in_masked = in_data & in_keep;
        shifted   = slots_p0 >> (popped * DATA);
        ins_data  = {{(ELMS*DATA){1'b0}}, in_masked} << (kept * DATA);
        ins_mask  = {{(ELMS*DATA){1'b0}}, in_keep} << (kept * DATA);
        slots_nxt = (shifted & ~ins_mask) | ins_data;
        occ_nxt   = kept + pushed;

        // A pending flush holds until the buffer is fully drained; a flush
        // that arrives with nothing left to emit is dropped.
        if (flush_pend_p0) begin
            flush_pend_nxt = (occ_nxt != '0);
        end else begin
            flush_pend_nxt = flush & (occ_nxt != '0);
        end
    end

    // ---- stage p0: element buffer, occupancy and flush state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_p0      <= '0;
            occ_p0        <= '0;
            flush_pend_p0 <= 1'b0;
        end else begin
            slots_p0      <= slots_nxt;
            occ_p0        <= occ_nxt;
            flush_pend_p0 <= flush_pend_nxt;
        end
    end

    // Output block is the bottom ELMS slots.
`ifdef BLOCK_PACK_ZERO_FILL_EN
    always_comb begin
        for (int i = 0; i < ELMS; i++) begin
            out_data[i] = (OCC_W'(i) < out_cnt_w) ? slots_p0[i] : '0;
        end
    end
`else
    assign out_data = slots_p0[ELMS-1:0];
`endif

endmodule

// File: tb/tb_block_pack.sv
// -----------------------------------------------------------------------------
// tb_block_pack
// Self-checking bench for block_pack (ELMS=8, DATA=8). A queue of element
// values plus a pending-flush bit model the packer; every cycle the DUT's
// handshake, count and block contents are compared against that model.
// Directed scenarios cover packing, backpressure, flush, simultaneous
// pop/push, asynchronous reset and count corners, followed by random traffic.
// -----------------------------------------------------------------------------
module tb_block_pack;

    localparam int E = 8;
    localparam int D = 8;
    localparam int C = $clog2(E + 1);
    localparam int W = E * D;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [E-1:0][D-1:0] in_data;
    logic [C-1:0]     in_cnt;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [E-1:0][D-1:0] out_data;
    logic [C-1:0]     out_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    bit fp = 1'b0;

    block_pack #(.ELMS(E), .DATA(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_cnt   (in_cnt),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Elements the model says are on offer this cycle (0 when nothing offered).
    function automatic int model_cnt();
        int s;
        s = q.size();
        if (s >= E) return E;
        if (fp && s > 0) return s;
        return 0;
    endfunction

    function automatic logic [W-1:0] seqd(input int n, input int base);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[i*D +: D] = D'(base + i);
        return d;
    endfunction

    task automatic compare();
        int oc;
        logic [W-1:0] ed;
        logic [W-1:0] gd;
        oc = model_cnt();
        ed = '0;
        for (int i = 0; i < oc; i++) ed[i*D +: D] = D'(q[i]);
        gd = out_data;
`ifndef BLOCK_PACK_ZERO_FILL_EN
        for (int i = oc; i < E; i++) gd[i*D +: D] = '0;
`endif
        check("in_ready",  W'(in_ready),  W'(q.size() <= E && !fp));
        check("out_valid", W'(out_valid), W'(oc > 0));
        check("out_cnt",   W'(out_cnt),   W'(oc));
        check("out_data",  gd, ed);
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the
    // falling edge.
    task automatic cycle(input logic v, input int c, input logic [W-1:0] d,
                         input logic fl, input logic ordy);
        int  oc;
        int  n;
        bit  rdy;
        in_valid  = v;
        in_cnt    = C'(c);
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
        oc  = model_cnt();
        rdy = (q.size() <= E) && !fp;
        @(posedge clk);
        if (ordy && oc > 0) repeat (oc) void'(q.pop_front());
        if (v && rdy) begin
            n = (c > E) ? E : c;
            for (int i = 0; i < n; i++) q.push_back(int'(d[i*D +: D]));
        end
        if (fp) begin
            if (q.size() == 0) fp = 1'b0;
        end else if (fl && q.size() > 0) begin
            fp = 1'b1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 0, '0, 1'b0, ordy);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_cnt    = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2;
        compare();
        @(negedge clk);
        reset = 1'b0;

        // Packing three groups of three into one block
        cycle(1'b1, 3, seqd(3, 1), 1'b0, 1'b1);
        cycle(1'b1, 3, seqd(3, 4), 1'b0, 1'b1);
        cycle(1'b1, 3, seqd(3, 7), 1'b0, 1'b1);
        check("pack_blk", W'(out_data), 64'h0807060504030201);
        idle(1'b1);
        cycle(1'b0, 0, '0, 1'b1, 1'b0);
        idle(1'b1);

        // Backpressure: two full blocks, third push stalls
        cycle(1'b1, 8, seqd(8, 1), 1'b0, 1'b0);
        cycle(1'b1, 8, seqd(8, 9), 1'b0, 1'b0);
        check("bp_ready", W'(in_ready), W'(0));
        cycle(1'b1, 8, seqd(8, 17), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush of a partial block
        cycle(1'b1, 5, seqd(5, 1), 1'b0, 1'b1);
        cycle(1'b0, 0, '0, 1'b1, 1'b0);
        check("flush_cnt", W'(out_cnt), W'(5));
`ifdef BLOCK_PACK_ZERO_FILL_EN
        check("flush_fill", W'(out_data), 64'h0000000504030201);
`endif
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);

        // Pop and push in the same cycle
        cycle(1'b1, 8, seqd(8, 1), 1'b0, 1'b0);
        cycle(1'b1, 2, seqd(2, 9), 1'b0, 1'b0);
        cycle(1'b1, 4, seqd(4, 11), 1'b0, 1'b1);
        cycle(1'b1, 4, seqd(4, 11), 1'b0, 1'b1);
        cycle(1'b1, 8, seqd(8, 20), 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b0, 0, '0, 1'b1, 1'b1);
        idle(1'b1);

        // Asynchronous reset with twelve elements buffered
        cycle(1'b1, 8, seqd(8, 1), 1'b0, 1'b0);
        cycle(1'b1, 4, seqd(4, 9), 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_ready", W'(in_ready),  W'(1));
        q.delete();
        fp = 1'b0;
        compare();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 8, seqd(8, 8'h21), 1'b0, 1'b0);
        check("rst_blk", W'(out_data), 64'h2827262524232221);
        idle(1'b1);

        // Count corners: zero and over-range
        cycle(1'b1, 3, seqd(3, 8'h40), 1'b0, 1'b0);
        cycle(1'b1, 0, seqd(8, 8'h90), 1'b0, 1'b0);
        cycle(1'b1, 12, seqd(8, 8'h50), 1'b0, 1'b0);
        idle(1'b1);
        cycle(1'b0, 0, '0, 1'b1, 1'b0);
        idle(1'b1);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 4) != 0,
                  int'($urandom_range(0, 12)),
                  {$urandom, $urandom},
                  ($urandom % 10) == 0,
                  ($urandom % 10) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/block_pack.md
BLOCK_PACK -- requirements
Module: block_pack

Interface
REQ-001 SHALL have parameter ELMS, default 8: element slots per block.
REQ-002 SHALL have parameter DATA, default 8: bits per element.
REQ-003 SHALL have parameter CNT, default $clog2(ELMS+1): element-count width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input group offered.
REQ-007 SHALL have port in_ready  output  1  input group accepted when in_valid & in_ready.
REQ-008 SHALL have port in_data  input  [ELMS-1:0][DATA-1:0]  elements, valid ones packed from element 0.
REQ-009 SHALL have port in_cnt  input  CNT  number of valid elements in in_data.
REQ-010 SHALL have port flush  input  1  single-cycle request to emit a partial block.
REQ-011 SHALL have port out_valid  output  1  output block offered.
REQ-012 SHALL have port out_ready  input  1  output block consumed when out_valid & out_ready.
REQ-013 SHALL have port out_data  output  [ELMS-1:0][DATA-1:0]  packed block, oldest element at element 0.
REQ-014 SHALL have port out_cnt  output  CNT  valid elements in out_data.

Function
REQ-015 SHALL hold 2*ELMS element registers plus occupancy occ (0..2*ELMS) and flag flush_pend.
REQ-016 SHALL drive in_ready = (occ <= ELMS) & ~flush_pend, from registered state only.
REQ-017 SHALL clamp in_cnt > ELMS to ELMS; accepted in_cnt = 0 SHALL change nothing.
REQ-018 SHALL append accepted element i at buffer slot (occ - popped + i), preserving arrival order.
REQ-019 SHALL drive out_valid = (occ >= ELMS) | (flush_pend & occ > 0); out_cnt = ELMS if occ >= ELMS, else occ; out_cnt = 0 when out_valid low.
REQ-020 SHALL present buffer slots 0..ELMS-1 on out_data; registered, no combinational path from in_* to out_*.
REQ-021 SHALL, on pop, shift remaining slots down by out_cnt (block shift toward element 0) and reduce occ by out_cnt.
REQ-022 SHALL apply simultaneous pop and push in one cycle: next occ = occ - out_cnt + clamped in_cnt.
REQ-023 SHALL have latency 1: element accepted at edge N is visible on out_data after edge N.
REQ-024 SHALL set flush_pend on flush when occ (post-update) > 0 and occ < ELMS after full blocks drain; flush with occ = 0 SHALL be ignored.
REQ-025 SHALL clear flush_pend on the pop that brings occ to 0; flush while flush_pend SHALL be ignored.
REQ-026 SHALL hold out_data, out_cnt stable while out_valid & ~out_ready.

Reset
REQ-027 SHALL on reset, asynchronously: occ = 0, flush_pend = 0, all slots zero, out_valid = 0, out_cnt = 0, out_data = 0, in_ready = 1.
REQ-028 SHALL discard all buffered elements when reset asserts mid-operation; no partial block emitted.

Configuration
REQ-029 SHALL honour macro BLOCK_PACK_ZERO_FILL_EN.
REQ-030 SHALL with BLOCK_PACK_ZERO_FILL_EN defined force out_data elements at index >= out_cnt to zero.
REQ-031 SHALL without BLOCK_PACK_ZERO_FILL_EN leave elements at index >= out_cnt as don't-care (stale slot contents).

Verification (ELMS=8, DATA=8, ZERO_FILL on)
REQ-032 Pack: push cnt 3 {1,2,3}, {4,5,6}, {7,8,9}, out_ready=1 -> one block {1..8} at elements 0..7, out_cnt 8; occ 1 holding 9.
REQ-033 Backpressure: out_ready=0, push cnt 8 twice -> occ 16, in_ready 0, third push stalls; out_ready=1 -> two blocks in order, then in_ready 1.
REQ-034 Flush: occ 5 {1..5}, pulse flush -> out_valid, out_cnt 5, elements 5..7 = 0, in_ready 0 until pop, then occ 0, in_ready 1.
REQ-035 Simultaneous: occ 10, out_ready=1, push cnt 4 {11..14} -> pop {1..8}, next occ 6 = {9,10,11,12,13,14}.
REQ-036 Reset mid-op: occ 12, assert reset -> out_valid 0, in_ready 1 without a clock edge; next 8 pushed elements form first block.
REQ-037 Corner counts: push in_cnt 0 -> occ unchanged; push in_cnt 12 -> treated as 8.
